// File: rtl/logic_unit_arbiter.sv
// Two-requester arbiter time-sharing one bitwise logic datapath (NOT/AND/OR/XOR).
// Round-robin grant in IDLE, one-cycle EXEC, then RESP held until the consumer accepts.
module logic_unit_arbiter #(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             req0_valid,
  input  logic [1:0]       req0_op,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  output logic             req0_ready,
  input  logic             req1_valid,
  input  logic [1:0]       req1_op,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  output logic             req1_ready,
  output logic             resp_valid,
  output logic             resp_id,
  output logic [WIDTH-1:0] resp_result,
  input  logic             resp_ready,
  output logic             busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    OP_NOT = 2'd0,
    OP_AND = 2'd1,
    OP_OR  = 2'd2,
    OP_XOR = 2'd3
  } op_t;

  state_t           state_q, state_d;
  logic             ptr_q;
  logic             hold_q;
  op_t              op_q;
  logic [WIDTH-1:0] a_q, b_q;
  logic             id_q;
  logic [WIDTH-1:0] result_q;

  logic             grant;
  logic             grant_id;
  logic [WIDTH-1:0] alu;

  // hold_q blocks grants for the first cycle after reset is released.
  assign grant    = (state_q == IDLE) && !reset && !hold_q && (req0_valid || req1_valid);
  assign grant_id = (req0_valid && req1_valid) ? ptr_q : req1_valid;

  always_comb begin
    // NOTE: every output of this block gets a default first so no latch is inferred.
    state_d    = state_q;
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    case (state_q)
      IDLE: begin
        if (grant) begin
          state_d    = EXEC;
          req0_ready = !grant_id;
          req1_ready = grant_id;
        end
      end
      EXEC:    state_d = RESP;
      RESP:    if (resp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    alu = '0;
    case (op_q)
      OP_NOT:  alu = ~a_q;
      OP_AND:  alu = a_q & b_q;
      OP_OR:   alu = a_q | b_q;
      OP_XOR:  alu = a_q ^ b_q;
      default: alu = '0;
    endcase
  end

  always_ff @(posedge clock) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (reset) begin
      state_q  <= IDLE;
      ptr_q    <= 1'b0;
      hold_q   <= 1'b1;
      op_q     <= OP_NOT;
      a_q      <= '0;
      b_q      <= '0;
      id_q     <= 1'b0;
      result_q <= '0;
    end else begin
      state_q <= state_d;
      hold_q  <= 1'b0;
      if (grant) begin
        id_q  <= grant_id;
        ptr_q <= !grant_id;
        op_q  <= op_t'(grant_id ? req1_op : req0_op);
        a_q   <= grant_id ? req1_a : req0_a;
        b_q   <= grant_id ? req1_b : req0_b;
      end
      if (state_q == EXEC) result_q <= alu;
    end
  end

  // Outputs are forced quiet while reset is asserted, even before the first reset edge.
  assign resp_valid  = (state_q == RESP) && !reset;
  assign busy        = (state_q != IDLE) && !reset;
  assign resp_id     = id_q && !reset;
  assign resp_result = reset ? '0 : result_q;

endmodule

// File: doc/logic_unit_arbiter.md
LOGIC_UNIT_ARBITER -- requirements
Module: logic_unit_arbiter

Interface
REQ-001 Parameter WIDTH, default 32, operand/result width in bits.
REQ-002 clock  input  1  rising-edge clock; all state updates on this edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 req0_valid  input  1  requester 0 has an operation pending.
REQ-005 req0_op  input  2  requester 0 opcode: 00 NOT A, 01 AND, 10 OR, 11 XOR.
REQ-006 req0_a, req0_b  input  WIDTH each  requester 0 operands.
REQ-007 req0_ready  output  1  requester 0 operation accepted this cycle.
REQ-008 req1_valid, req1_op, req1_a, req1_b, req1_ready  same widths/directions/meanings as REQ-004..REQ-007, for requester 1.
REQ-009 resp_valid  output  1  result available.
REQ-010 resp_id  output  1  requester owning the current result (0 or 1).
REQ-011 resp_result  output  WIDTH  computed result.
REQ-012 resp_ready  input  1  consumer takes the result this cycle.
REQ-013 busy  output  1  high whenever FSM is not IDLE.

Function
REQ-014 Block SHALL time-share one WIDTH-bit bitwise logic datapath between two requesters with a 3-state FSM: IDLE, EXEC, RESP.
REQ-015 IDLE: if any reqN_valid is high, grant one requester, assert its reqN_ready combinationally in that cycle, capture op, a, b and id into internal registers, move to EXEC; otherwise stay in IDLE.
REQ-016 reqN_ready SHALL be high only in IDLE, for the granted requester only; both readies never high together.
REQ-017 Arbitration SHALL be round-robin: priority pointer selects the preferred requester when both valid; after every grant the pointer points to the non-granted requester; if only one is valid it is granted regardless of pointer.
REQ-018 EXEC: compute result from captured registers into result register: NOT -> ~a (b ignored), AND -> a&b, OR -> a|b, XOR -> a^b; move to RESP; lasts exactly one cycle.
REQ-019 RESP: resp_valid high; resp_result and resp_id held stable until handshake; on resp_valid&&resp_ready move to IDLE the next cycle.
REQ-020 Latency: grant in cycle t -> resp_valid first high in cycle t+2; minimum issue interval 3 cycles.
REQ-021 Requester inputs changing after grant SHALL NOT affect the in-flight result.
REQ-022 reqN_valid SHALL be ignored (no ready, no pointer change) while in EXEC or RESP.
REQ-023 resp_ready asserted outside RESP SHALL have no effect.
REQ-024 Operations are purely bitwise: no carry, no sign extension, all WIDTH bits independent.

Reset
REQ-025 On reset high at a clock edge: FSM -> IDLE, pointer -> requester 0, result register -> 0, captured op/operands/id -> 0.
REQ-026 While reset is high and in the cycle following its release, outputs SHALL be: req0_ready=0, req1_ready=0, resp_valid=0, resp_id=0, resp_result=0, busy=0.
REQ-027 Reset asserted in EXEC or RESP SHALL abort the in-flight operation; no response for it is ever produced.
REQ-028 Grants SHALL begin no earlier than the first cycle after reset deasserts.

Verification
REQ-029 Single request: req0 NOT, a=0x0000FFFF, resp_ready=1 -> req0_ready at t, resp_valid at t+2 with resp_result=0xFFFF0000, resp_id=0, IDLE at t+3.
REQ-030 Contention: both valid continuously after reset, req0 AND a=0xF0F0F0F0 b=0xFF00FF00, req1 XOR a=0xAAAAAAAA b=0xFFFFFFFF -> grants alternate 0,1,0,1; results 0xF000F000 (id 0) and 0x55555555 (id 1).
REQ-031 Backpressure: resp_ready=0 for 5 cycles in RESP with OR a=0x12340000 b=0x00005678 -> resp_valid held, resp_result=0x12345678 stable, no req_ready asserted; release -> IDLE next cycle.
REQ-032 Operand mutation: change req1_a to 0 one cycle after grant of AND a=0xFFFFFFFF b=0x0F0F0F0F -> result still 0x0F0F0F0F.
REQ-033 Reset mid-operation: assert reset in EXEC -> next cycle busy=0, resp_valid=0, resp_result=0, pointer at requester 0; no response emitted for aborted op.
REQ-034 Single-sided repeat: only req1 valid for 3 ops -> req1 granted each time at 3-cycle spacing despite pointer.
